// File: rtl/clock_pkg.sv
// Constants and types shared by the digital-clock counter stages.
package clock_pkg;

  localparam int HOUR_W    = 5;
  localparam int HOUR_MAX  = 23;
  localparam int HOUR_NOON = 12;
  localparam int MIN_MAX   = 59;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] ones;
    logic       pm;
  } disp_t;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one history flop plus AND, with a selectable reset value.
module edge_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, matching the hardware.
  always_ff @(posedge clk_i) begin
    if (rst_i) hist_q <= RESET_VAL;
    else       hist_q <= d_i;
  end

  assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/counter_hour.sv
// Hour stage of the digital clock: advances on each carry_min rising edge,
// supports manual setting, and drives registered 12h/24h BCD display digits.
module counter_hour #(
  parameter int HOUR_W     = clock_pkg::HOUR_W,
  parameter int RESET_HOUR = 0
) (
  input  logic              clock,
  input  logic              reset_hour,
  input  logic              load_hour,
  input  logic              setting_hour,
  input  logic              carry_min,
  input  logic              mode_24,
  output logic [HOUR_W-1:0] count_hour,
  output logic [1:0]        disp_tens,
  output logic [3:0]        disp_ones,
  output logic              pm,
  output logic              carry_hour
);

  import clock_pkg::*;

  localparam logic [HOUR_W-1:0] MAX_C    = HOUR_W'(HOUR_MAX);
  localparam logic [HOUR_W-1:0] NOON_C   = HOUR_W'(HOUR_NOON);
  localparam logic [HOUR_W-1:0] RESET_C  = HOUR_W'(RESET_HOUR);
  localparam logic [HOUR_W-1:0] ONE_C    = HOUR_W'(1);
  localparam logic [HOUR_W-1:0] TEN_C    = HOUR_W'(10);
  localparam logic [HOUR_W-1:0] TWENTY_C = HOUR_W'(20);
  localparam logic [HOUR_W-1:0] THIRTY_C = HOUR_W'(30);

  logic              inc_c, inc_s;
  logic [HOUR_W-1:0] count_q, count_d, next_hour;
  logic              carry_q, carry_d;
  disp_t             disp_q, disp_d;
  logic [HOUR_W-1:0] disp_src, disp_h;

  edge_rise #(.RESET_VAL(1'b1)) u_carry_edge (
    .clk_i  (clock),
    .rst_i  (reset_hour),
    .d_i    (carry_min),
    .rise_o (inc_c)
  );

  edge_rise #(.RESET_VAL(1'b1)) u_set_edge (
    .clk_i  (clock),
    .rst_i  (reset_hour),
    .d_i    (setting_hour),
    .rise_o (inc_s)
  );

  // Anything at or above 23 (including a corrupted reset value) wraps to 0.
  assign next_hour = (count_q >= MAX_C) ? '0 : count_q + ONE_C;

  // NOTE: every variable driven here gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (load_hour) begin
      if (inc_s) count_d = next_hour;
    end else if (inc_c) begin
      count_d = next_hour;
      carry_d = (count_q >= MAX_C);
    end
  end

  // Display source follows reset so the digits come out of reset already
  // matching RESET_HOUR in the current mode.
  always_comb begin
    disp_src = reset_hour ? RESET_C : count_q;
    disp_h   = disp_src;
    if (!mode_24) begin
      if (disp_src == '0 || disp_src == NOON_C) disp_h = NOON_C;
      else if (disp_src > NOON_C)               disp_h = disp_src - NOON_C;
    end

    disp_d.pm = (disp_src >= NOON_C);
    if (disp_h >= THIRTY_C) begin
      disp_d.tens = 2'd3;
      disp_d.ones = 4'(disp_h - THIRTY_C);
    end else if (disp_h >= TWENTY_C) begin
      disp_d.tens = 2'd2;
      disp_d.ones = 4'(disp_h - TWENTY_C);
    end else if (disp_h >= TEN_C) begin
      disp_d.tens = 2'd1;
      disp_d.ones = 4'(disp_h - TEN_C);
    end else begin
      disp_d.tens = 2'd0;
      disp_d.ones = 4'(disp_h);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_hour) begin
      count_q <= RESET_C;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  always_ff @(posedge clock) begin
    disp_q <= disp_d;
  end

  assign count_hour = count_q;
  assign carry_hour = carry_q;
  assign disp_tens  = disp_q.tens;
  assign disp_ones  = disp_q.ones;
  assign pm         = disp_q.pm;

endmodule

// File: tb/tb_counter_hour.sv
// Scoreboard bench for counter_hour: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_counter_hour;

  logic       clock = 1'b0;
  logic       reset_hour, load_hour, setting_hour, carry_min, mode_24;
  logic [4:0] count_hour;
  logic [1:0] disp_tens;
  logic [3:0] disp_ones;
  logic       pm, carry_hour;

  counter_hour #(.HOUR_W(5), .RESET_HOUR(0)) dut (
    .clock        (clock),
    .reset_hour   (reset_hour),
    .load_hour    (load_hour),
    .setting_hour (setting_hour),
    .carry_min    (carry_min),
    .mode_24      (mode_24),
    .count_hour   (count_hour),
    .disp_tens    (disp_tens),
    .disp_ones    (disp_ones),
    .pm           (pm),
    .carry_hour   (carry_hour)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         tgt;
    string      name;
    logic [4:0] cnt;
    logic       car;
    bit         dchk;
    logic [1:0] tens;
    logic [3:0] ones;
    logic       pm;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every expectation whose target cycle has been reached.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".when"}, cyc, e.tgt);
      check({e.name, ".count"}, int'(count_hour), int'(e.cnt));
      check({e.name, ".carry"}, int'(carry_hour), int'(e.car));
      if (e.dchk) begin
        check({e.name, ".tens"}, int'(disp_tens), int'(e.tens));
        check({e.name, ".ones"}, int'(disp_ones), int'(e.ones));
        check({e.name, ".pm"},   int'(pm),        int'(e.pm));
      end
    end
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_cnt(input string name, input int cnt, input bit car);
    exp_t e;
    e.tgt = cyc; e.name = name; e.cnt = 5'(cnt); e.car = car;
    e.dchk = 1'b0; e.tens = '0; e.ones = '0; e.pm = 1'b0;
    sb.push_back(e);
  endtask

  task automatic exp_all(input string name, input int cnt, input bit car,
                         input int tens, input int ones, input bit p);
    exp_t e;
    e.tgt = cyc; e.name = name; e.cnt = 5'(cnt); e.car = car;
    e.dchk = 1'b1; e.tens = 2'(tens); e.ones = 4'(ones); e.pm = p;
    sb.push_back(e);
  endtask

  task automatic set_pulses(input int n);
    repeat (n) begin
      setting_hour = 1'b1; sync();
      setting_hour = 1'b0; sync();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_hour = 1'b1; load_hour = 1'b0; setting_hour = 1'b0;
    carry_min  = 1'b1; mode_24   = 1'b0;

    // Reset with carry_min held high; 12h display of hour 0 is 12 am.
    sync(); sync();
    exp_all("reset", 0, 0, 1, 2, 0);
    reset_hour = 1'b0;
    sync(); sync(); sync();
    exp_all("release_carry_high", 0, 0, 1, 2, 0);
    carry_min = 1'b0;
    sync();

    // Eleven three-cycle carry pulses.
    for (int i = 1; i <= 11; i++) begin
      carry_min = 1'b1; sync();
      exp_cnt($sformatf("pulse%0d", i), i, 0);
      sync(); sync();
      carry_min = 1'b0; sync();
    end
    exp_all("eleven_12h", 11, 0, 1, 1, 0);
    mode_24 = 1'b1; sync(); sync();
    exp_all("eleven_24h", 11, 0, 1, 1, 0);

    // Preset to 23 in set mode, then roll over with one carry pulse.
    load_hour = 1'b1;
    set_pulses(12);
    exp_all("preset23", 23, 0, 2, 3, 1);
    load_hour = 1'b0; sync();
    exp_cnt("pre_roll", 23, 0);
    carry_min = 1'b1; sync();
    exp_all("roll", 0, 1, 2, 3, 1);
    sync();
    exp_all("roll_after", 0, 0, 0, 0, 0);
    carry_min = 1'b0; sync();

    // Set-mode wrap 23->0 gives no carry; carry edges during set mode are lost.
    load_hour = 1'b1;
    set_pulses(23);
    exp_cnt("set_to_23", 23, 0);
    setting_hour = 1'b1; sync();
    exp_cnt("set_wrap", 0, 0);
    setting_hour = 1'b0; sync();
    exp_cnt("set_wrap_after", 0, 0);
    carry_min = 1'b1; sync();
    exp_cnt("carry_in_load", 0, 0);
    sync();
    load_hour = 1'b0; sync(); sync();
    exp_cnt("load_fall_carry_high", 0, 0);
    carry_min = 1'b0; sync();

    // Hour 13: mode toggles change only the display.
    load_hour = 1'b1;
    set_pulses(13);
    load_hour = 1'b0; sync();
    exp_all("h13_24h", 13, 0, 1, 3, 1);
    mode_24 = 1'b0; sync();
    exp_all("h13_12h", 13, 0, 0, 1, 1);
    mode_24 = 1'b1; sync();
    exp_all("h13_back24", 13, 0, 1, 3, 1);

    // Mid-count reset at 17 with carry and setting rising in the same cycle.
    load_hour = 1'b1;
    set_pulses(4);
    load_hour = 1'b0; sync();
    exp_cnt("h17", 17, 0);
    reset_hour = 1'b1; carry_min = 1'b1; setting_hour = 1'b1;
    sync();
    exp_all("mid_reset", 0, 0, 0, 0, 0);
    reset_hour = 1'b0;
    sync(); sync();
    exp_all("mid_reset_release", 0, 0, 0, 0, 0);
    carry_min = 1'b0; setting_hour = 1'b0;
    sync(); sync();

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_hour.md
Name: counter_hour

Overview:
- Hour stage of the digital clock, directly downstream of the minute counter.
- Consumes the minute counter's carry_min, a level held high while minutes sit at 59. Advances the hour once per carry rising edge.
- Supports manual hour setting and a 12h/24h display format.
- Produces registered BCD digits for the display driver and a one-cycle day-rollover pulse for a future date stage.

Parameters:
- HOUR_W, 5, width of the internal hour count (holds 0..23).
- RESET_HOUR, 0, value loaded into count_hour on reset; legal range 0..23.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_hour  input  1  synchronous, active-high reset.
- load_hour  input  1  set mode; while high, carry_min is ignored and setting_hour edits the hour.
- setting_hour  input  1  set-mode increment request; one increment per rising edge.
- carry_min  input  1  carry level from the minute counter.
- mode_24  input  1  1 = 24h display (0..23), 0 = 12h display (1..12 with pm).
- count_hour  output  HOUR_W  internal hour, always 0..23.
- disp_tens  output  2  BCD tens digit of the displayed hour.
- disp_ones  output  4  BCD ones digit of the displayed hour.
- pm  output  1  1 when count_hour >= 12; valid in both modes.
- carry_hour  output  1  one-cycle pulse on the 23->0 rollover caused by carry_min.

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything else. On reset:
  - count_hour = RESET_HOUR; carry_hour = 0.
  - Display registers load the value matching RESET_HOUR and the current mode_24. For the default RESET_HOUR=0: 24h gives tens=0, ones=0; 12h gives tens=1, ones=2; pm=0.
  - Both edge-detector history flops load 1, so an input already high at reset release does not produce an event.
- Edge detection:
  - inc_c = carry_min & ~carry_min_q.
  - inc_s = setting_hour & ~setting_hour_q.
  - History flops update every non-reset cycle, regardless of load_hour.
- Priority after reset:
  1. load_hour=1: on inc_s, count_hour = (count_hour==23) ? 0 : count_hour+1. carry_hour stays 0, including on a 23->0 set wrap. inc_c is discarded; a carry edge during set mode is lost, not queued.
  2. load_hour=0 with inc_c: count_hour = (count_hour==23) ? 0 : count_hour+1. carry_hour = 1 for exactly that cycle only when wrapping 23->0.
  3. Otherwise count_hour holds and carry_hour = 0.
- Latency:
  - count_hour updates on the clock edge where the input edge is sampled, i.e. one cycle after carry_min rises.
  - carry_hour is registered and asserts in the same cycle count_hour becomes 0.
- Display pipeline, registered, one cycle after count_hour or mode_24 changes:
  - 24h: displayed value h = count_hour.
  - 12h: h = 12 when count_hour is 0 or 12; h = count_hour-12 when count_hour > 12; otherwise h = count_hour.
  - disp_tens = h/10, disp_ones = h%10. pm = (count_hour >= 12).
  - A mode_24 toggle alone never alters count_hour.
- A carry_min held high for many cycles yields exactly one increment. The next increment requires carry_min to fall and rise again.
- load_hour falling while carry_min is high produces no increment; its rising edge already passed.
- No illegal states: count_hour never leaves 0..23. Any out-of-range value, e.g. a corrupted RESET_HOUR, wraps to 0 on its next increment.
- No FSM beyond the edge history; the design is a counter with a priority mux.

Decomposition:
- Shared package clock_pkg:
  - HOUR_MAX=23, HOUR_NOON=12, HOUR_W=5.
  - Also MIN_MAX=59, so minute and hour stages share constants.
- Sub-module edge_rise: one flop plus AND. Its reset value is a port-level parameter (set to 1 here). Instantiated twice, for carry_min and setting_hour; reusable by the minute stage later.
- Binary-to-BCD for 0..23 stays inline as a compare/subtract on the display register input; no separate module.

Test Plan:
- Reset with carry_min held high, then released -> count_hour=0, no increment while carry_min stays high. 12h display reads tens=1, ones=2, pm=0.
- Eleven carry_min pulses of three cycles each from 0 -> count_hour=11, one increment per pulse. 12h reads 1,1 with pm=0; 24h reads 1,1.
- Preset to 23 via set mode, exit, one carry_min pulse -> count_hour=0 and carry_hour=1 for exactly one cycle, one cycle after the carry_min rising edge.
- load_hour=1, setting_hour edge at count 23 -> count_hour=0 with carry_hour=0. A carry_min edge during load_hour=1 -> no change.
- count_hour=13 with mode_24 toggled 1->0 -> one cycle later tens=0, ones=1, pm=1; toggle back -> tens=1, ones=3; count_hour unchanged throughout.
- Mid-count reset at count_hour=17 with carry_min and setting_hour both rising in the same cycle as reset_hour -> next cycle count_hour=0, carry_hour=0, and no increment after release.
